// File: rtl/matrix_tile_loader_if.sv
`timescale 1ns/1ps
// Signal bundle between the word source / multiplier (master) and the
// tile loader (slave): the word stream handshake plus the presented tile.
interface matrix_tile_loader_if #(
  parameter int WORD_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  logic [WORD_WIDTH-1:0]  input_Word;
  logic                   input_Word_Valid;
  logic                   output_Word_Ready;
  logic                   input_Flush;
  logic                   input_AB_Ack;
  logic                   output_Stable;
  logic [WORD_WIDTH-1:0]  output_A11;
  logic [WORD_WIDTH-1:0]  output_A12;
  logic [WORD_WIDTH-1:0]  output_A21;
  logic [WORD_WIDTH-1:0]  output_A22;
  logic [WORD_WIDTH-1:0]  output_B11;
  logic [WORD_WIDTH-1:0]  output_B12;
  logic [WORD_WIDTH-1:0]  output_B21;
  logic [WORD_WIDTH-1:0]  output_B22;
  logic [COUNT_WIDTH-1:0] output_Tile_Count;
  logic                   output_Protocol_Err;

  modport master (
    output input_Word, input_Word_Valid, input_Flush, input_AB_Ack,
    input  output_Word_Ready, output_Stable,
    input  output_A11, output_A12, output_A21, output_A22,
    input  output_B11, output_B12, output_B21, output_B22,
    input  output_Tile_Count, output_Protocol_Err
  );

  modport slave (
    input  input_Word, input_Word_Valid, input_Flush, input_AB_Ack,
    output output_Word_Ready, output_Stable,
    output output_A11, output_A12, output_A21, output_A22,
    output output_B11, output_B12, output_B21, output_B22,
    output output_Tile_Count, output_Protocol_Err
  );
endinterface

// File: rtl/matrix_tile_loader.sv
`timescale 1ns/1ps
// Assembles eight streamed operands into a 2x2 A/B tile and presents it to the
// multiplier. Define TILE_LOADER_DBUF_EN to fill the next tile while presenting.
module matrix_tile_loader #(
  parameter int WORD_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                 input_Clk,
  input  logic                 input_Reset,
  matrix_tile_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [2:0]             write_index;
  logic                   fill_full;
  logic [WORD_WIDTH-1:0]  fill_bank [8];
  logic [WORD_WIDTH-1:0]  tile      [8];
  logic [WORD_WIDTH-1:0]  next_tile [8];
  logic                   word_ready;
  logic                   word_xfer;
  logic                   last_xfer;
  logic                   fill_done;
  logic                   load_tile;
  logic                   count_inc;
  logic [COUNT_WIDTH-1:0] tile_count;
  logic                   protocol_err;

  // With two banks the fill bank keeps accepting until it holds a whole tile;
  // with one bank words are only taken while nothing is being presented.
  always_comb begin
`ifdef TILE_LOADER_DBUF_EN
    word_ready = !input_Reset && !bus.input_Flush && !fill_full;
`else
    word_ready = !input_Reset && !bus.input_Flush && (state == FILL);
`endif
  end

  // The tile about to be loaded includes the word arriving on this edge.
  always_comb begin
    word_xfer = bus.input_Word_Valid && word_ready;
    last_xfer = word_xfer && (write_index == 3'd7);
    fill_done = !bus.input_Flush && (fill_full || last_xfer);
    for (int i = 0; i < 8; i++) begin
      next_tile[i] = fill_bank[i];
    end
    if (word_xfer) begin
      next_tile[write_index] = bus.input_Word;
    end
  end

  always_ff @(posedge input_Clk or posedge input_Reset) begin
    if (input_Reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // RELEASE waits for the acknowledge to fall so a lingering ack cannot
  // retire the following tile.
  always_comb begin
    state_next = state;
    load_tile  = 1'b0;
    count_inc  = 1'b0;
    case (state)
      FILL: begin
        if (last_xfer) begin
          state_next = PRESENT;
          load_tile  = 1'b1;
        end
      end
      PRESENT: begin
        if (bus.input_AB_Ack) begin
          state_next = RELEASE;
          count_inc  = 1'b1;
        end
      end
      RELEASE: begin
        if (!bus.input_AB_Ack) begin
          if (fill_done) begin
            state_next = PRESENT;
            load_tile  = 1'b1;
          end else begin
            state_next = FILL;
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  // Flush only ever touches the fill side; a presented tile is untouched.
  always_ff @(posedge input_Clk or posedge input_Reset) begin
    if (input_Reset) begin
      write_index <= '0;
      fill_full   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        fill_bank[i] <= '0;
      end
    end else if (bus.input_Flush) begin
      write_index <= '0;
      fill_full   <= 1'b0;
    end else begin
      if (word_xfer) begin
        fill_bank[write_index] <= bus.input_Word;
        write_index            <= write_index + 3'd1;
      end
      if (load_tile) begin
        fill_full <= 1'b0;
      end else if (last_xfer) begin
        fill_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge input_Clk or posedge input_Reset) begin
    if (input_Reset) begin
      for (int i = 0; i < 8; i++) begin
        tile[i] <= '0;
      end
      tile_count   <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (load_tile) begin
        for (int i = 0; i < 8; i++) begin
          tile[i] <= next_tile[i];
        end
      end
      if (count_inc) begin
        tile_count <= tile_count + COUNT_WIDTH'(1);
      end
      if ((state == FILL) && bus.input_AB_Ack) begin
        protocol_err <= 1'b1;
      end
    end
  end

  assign bus.output_Word_Ready   = word_ready;
  assign bus.output_Stable       = (state == PRESENT);
  assign bus.output_A11          = tile[0];
  assign bus.output_A12          = tile[1];
  assign bus.output_A21          = tile[2];
  assign bus.output_A22          = tile[3];
  assign bus.output_B11          = tile[4];
  assign bus.output_B12          = tile[5];
  assign bus.output_B21          = tile[6];
  assign bus.output_B22          = tile[7];
  assign bus.output_Tile_Count   = tile_count;
  assign bus.output_Protocol_Err = protocol_err;

endmodule

// File: tb/tb_matrix_tile_loader.sv
`timescale 1ns/1ps
// Self-checking bench for matrix_tile_loader: a directed vector table, directed
// corner sequences, then randomized traffic against a queue-based tile model.
module tb_matrix_tile_loader;
  localparam int WW = 32;
  localparam int CW = 16;
`ifdef TILE_LOADER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks;
  int   errors;

  matrix_tile_loader_if #(.WORD_WIDTH(WW), .COUNT_WIDTH(CW)) bus ();

  matrix_tile_loader #(.WORD_WIDTH(WW), .COUNT_WIDTH(CW)) dut (
    .input_Clk   (clk),
    .input_Reset (rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [31:0] word;
    bit          flush;
    bit          ack;
    bit          exp_ready;
    bit          exp_stable;
    logic [15:0] exp_count;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  // Reference model: words collected so far, the tile on the outputs, and
  // whether that tile is shown, awaiting ack release, or nothing is shown.
  int          m_phase;
  logic [31:0] m_pending[$];
  logic [31:0] m_tile [8];
  logic [15:0] m_count;
  bit          m_err;

  bit          ack_r;
  int          wait_cnt;
  int          hold_cnt;

  function automatic logic [31:0] fval(input int n);
    case (n)
      1:  return 32'h3F800000;
      2:  return 32'h40000000;
      3:  return 32'h40400000;
      4:  return 32'h40800000;
      5:  return 32'h40A00000;
      6:  return 32'h40C00000;
      7:  return 32'h40E00000;
      8:  return 32'h41000000;
      9:  return 32'h41100000;
      10: return 32'h41200000;
      11: return 32'h41300000;
      12: return 32'h41400000;
      13: return 32'h41500000;
      14: return 32'h41600000;
      15: return 32'h41700000;
      16: return 32'h41800000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] operand(input int i);
    case (i)
      0: return bus.output_A11;
      1: return bus.output_A12;
      2: return bus.output_A21;
      3: return bus.output_A22;
      4: return bus.output_B11;
      5: return bus.output_B12;
      6: return bus.output_B21;
      default: return bus.output_B22;
    endcase
  endfunction

  function automatic vec_t mk(input bit v, input logic [31:0] w, input bit f, input bit a,
                              input bit er, input bit es, input logic [15:0] ec, input bit ee);
    vec_t r;
    r.valid = v; r.word = w; r.flush = f; r.ack = a;
    r.exp_ready = er; r.exp_stable = es; r.exp_count = ec; r.exp_err = ee;
    return r;
  endfunction

  function automatic bit model_ready();
    return !bus.input_Flush && (m_pending.size() < 8) && (DBUF || m_phase == 0);
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_pending.delete();
    for (int i = 0; i < 8; i++) m_tile[i] = '0;
    m_count = '0;
    m_err   = 1'b0;
  endtask

  task automatic model_take_tile();
    for (int i = 0; i < 8; i++) m_tile[i] = m_pending[i];
    m_pending.delete();
    m_phase = 1;
  endtask

  task automatic model_edge();
    bit xfer;
    xfer = bus.input_Word_Valid && model_ready();
    if (bus.input_Flush) m_pending.delete();
    else if (xfer) m_pending.push_back(bus.input_Word);
    case (m_phase)
      0: begin
        if (bus.input_AB_Ack) m_err = 1'b1;
        if (m_pending.size() == 8) model_take_tile();
      end
      1: begin
        if (bus.input_AB_Ack) begin
          m_count = m_count + 16'd1;
          m_phase = 2;
        end
      end
      default: begin
        if (!bus.input_AB_Ack) begin
          if (m_pending.size() == 8) model_take_tile();
          else m_phase = 0;
        end
      end
    endcase
  endtask

  task automatic applyStimulus(input bit valid, input logic [31:0] word, input bit flush, input bit ack);
    bus.input_Word_Valid = valid;
    bus.input_Word       = word;
    bus.input_Flush      = flush;
    bus.input_AB_Ack     = ack;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkFloatTile(input string name, input int first);
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("%s op%0d", name, i), operand(i), fval(first + i));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    checkOutput("reset ready", 32'(bus.output_Word_Ready), 32'd0);
    checkOutput("reset stable", 32'(bus.output_Stable), 32'd0);
    checkOutput("reset count", 32'(bus.output_Tile_Count), 32'd0);
    checkOutput("reset err", 32'(bus.output_Protocol_Err), 32'd0);
    for (int i = 0; i < 8; i++) checkOutput($sformatf("reset op%0d", i), operand(i), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    ack_r  = 1'b0;
    wait_cnt = 0;
    hold_cnt = 0;
    doReset();

`ifndef TILE_LOADER_DBUF_EN
    // Ack in FILL flags an error, a partial tile is flushed, a full tile is acked.
    vecs.push_back(mk(0, 32'h0,        0, 1, 1, 0, 16'd0, 1));
    vecs.push_back(mk(1, 32'h12345678, 0, 0, 1, 0, 16'd0, 1));
    vecs.push_back(mk(1, 32'h9ABCDEF0, 1, 0, 0, 0, 16'd0, 1));
    for (int k = 1; k <= 8; k++) vecs.push_back(mk(1, fval(k), 0, 0, 1, k == 8, 16'd0, 1));
    vecs.push_back(mk(1, 32'hDEADBEEF, 0, 0, 0, 1, 16'd0, 1));
    vecs.push_back(mk(0, 32'h0,        0, 1, 0, 0, 16'd1, 1));
    vecs.push_back(mk(0, 32'h0,        0, 1, 0, 0, 16'd1, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 0, 0, 16'd1, 1));
    vecs.push_back(mk(0, 32'h0,        0, 0, 1, 0, 16'd1, 1));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].valid, vecs[i].word, vecs[i].flush, vecs[i].ack);
      #1;
      checkOutput($sformatf("vec%0d ready", i), 32'(bus.output_Word_Ready), 32'(vecs[i].exp_ready));
      tick();
      checkOutput($sformatf("vec%0d stable", i), 32'(bus.output_Stable), 32'(vecs[i].exp_stable));
      checkOutput($sformatf("vec%0d count", i), 32'(bus.output_Tile_Count), 32'(vecs[i].exp_count));
      checkOutput($sformatf("vec%0d err", i), 32'(bus.output_Protocol_Err), 32'(vecs[i].exp_err));
    end
    checkFloatTile("table tile", 1);

    // Stream with valid held high, then a long multiplier acknowledge.
    doReset();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, fval(k), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'hFFFF0000, 1'b0, 1'b0);
    #1 checkOutput("present ready", 32'(bus.output_Word_Ready), 32'd0);
    tick();
    checkOutput("latency stable", 32'(bus.output_Stable), 32'd1);
    checkFloatTile("stream tile", 1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("ack stable", 32'(bus.output_Stable), 32'd0);
    checkOutput("ack count", 32'(bus.output_Tile_Count), 32'd1);
    repeat (9) tick();
    checkOutput("release ready", 32'(bus.output_Word_Ready), 32'd0);
    checkOutput("release count", 32'(bus.output_Tile_Count), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #1 checkOutput("ack fall ready before", 32'(bus.output_Word_Ready), 32'd0);
    tick();
    checkOutput("ack fall ready after", 32'(bus.output_Word_Ready), 32'd1);
    checkFloatTile("held tile", 1);
`endif

    // Partial tile discarded by flush.
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 32'hBAD00000 + 32'(k), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, 32'hBAD000FF, 1'b1, 1'b0);
    #1 checkOutput("flush ready", 32'(bus.output_Word_Ready), 32'd0);
    tick();
    for (int k = 9; k <= 16; k++) begin
      applyStimulus(1'b1, fval(k), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("flush stable", 32'(bus.output_Stable), 32'd1);
    checkFloatTile("flush tile", 9);

    // Async reset while a tile is presented.
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("pre-reset count", 32'(bus.output_Tile_Count), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, fval(k), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("pre-reset stable", 32'(bus.output_Stable), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    checkOutput("async rst stable", 32'(bus.output_Stable), 32'd0);
    checkOutput("async rst A11", bus.output_A11, 32'd0);
    checkOutput("async rst B22", bus.output_B22, 32'd0);
    checkOutput("async rst count", 32'(bus.output_Tile_Count), 32'd0);
    checkOutput("async rst ready", 32'(bus.output_Word_Ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("post rst ready", 32'(bus.output_Word_Ready), 32'd1);
    checkOutput("post rst err", 32'(bus.output_Protocol_Err), 32'd0);

`ifdef TILE_LOADER_DBUF_EN
    // Second tile fills while the first is presented, then swaps in on release.
    doReset();
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b1, fval(k), 1'b0, 1'b0);
      #1 checkOutput($sformatf("dbuf ready w%0d", k), 32'(bus.output_Word_Ready), 32'd1);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    #1 checkOutput("dbuf full ready", 32'(bus.output_Word_Ready), 32'd0);
    tick();
    checkOutput("dbuf ack1 count", 32'(bus.output_Tile_Count), 32'd1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("dbuf swap stable", 32'(bus.output_Stable), 32'd1);
    checkFloatTile("dbuf tile2", 9);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    checkOutput("dbuf ack2 count", 32'(bus.output_Tile_Count), 32'd2);
    checkOutput("dbuf idle stable", 32'(bus.output_Stable), 32'd0);
`endif

    // Randomized traffic with a well-behaved multiplier acknowledge.
    doReset();
    ack_r = 1'b0;
    wait_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (m_phase == 1 && !ack_r) begin
        if (wait_cnt == 0) begin
          ack_r = 1'b1;
          hold_cnt = int'($urandom_range(1, 4));
        end else begin
          wait_cnt--;
        end
      end else if (m_phase == 2 && ack_r) begin
        if (hold_cnt > 1) begin
          hold_cnt--;
        end else begin
          ack_r = 1'b0;
          wait_cnt = int'($urandom_range(0, 3));
        end
      end
      applyStimulus(($urandom % 10) < 7, $urandom, ($urandom % 25) == 0, ack_r);
      #1 checkOutput("rand ready", 32'(bus.output_Word_Ready), 32'(model_ready()));
      tick();
      checkOutput("rand stable", 32'(bus.output_Stable), 32'(m_phase == 1));
      checkOutput("rand count", 32'(bus.output_Tile_Count), 32'(m_count));
      checkOutput("rand err", 32'(bus.output_Protocol_Err), 32'(m_err));
      for (int i = 0; i < 8; i++) checkOutput($sformatf("rand op%0d", i), operand(i), m_tile[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
